// File: rtl/phase_seq_fsm.sv
// Multi-channel four-phase sequencer: per-channel sync + debounce feeding an
// IDLE->START->STOP->CLEAR tracker with timeout. Macro PHASE_SEQ_CNT_EN adds a completed-sequence counter.

module phase_seq_ch #(
    parameter int DEB_W   = 4,
    parameter int DEB_CNT = 8,
    parameter int TO_W    = 16,
    parameter int TO_CNT  = 1000,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             a_i,
    input  logic             clr_to_i,
    output logic             k1_o,
    output logic             k2_o,
    output logic             to_flag_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cyc_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11} state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CNT - 1);

    logic             s1_q, s2_q, af_q, af_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             rise_q, fall_q;
    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             k1_q, k1_d, k2_q, k2_d, to_flag_q, to_flag_d, to_set;

    // A level change is accepted on the DEB_CNT-th consecutive disagreeing cycle
    always_comb begin
        deb_cnt_d = '0;
        af_d      = af_q;
        if (s2_q != af_q) begin
            if (deb_cnt_q == DEB_LAST) af_d = ~af_q;
            else                       deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        to_set   = 1'b0;
        k2_d     = 1'b0;
        if (en_i) begin
            case (state_q)
                IDLE:    if (rise_q) state_d = START;
                START:   if (fall_q) state_d = STOP;
                STOP:    if (rise_q) state_d = CLEAR;
                CLEAR:   if (fall_q) begin state_d = IDLE; k2_d = 1'b1; end
                default: state_d = IDLE;
            endcase
            // An edge in the same cycle wins over timeout: the counter only runs while state holds
            if (TO_CNT != 0 && state_d == state_q && state_q != IDLE) begin
                if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        end else begin
            state_d = IDLE;
        end
        k1_d      = (state_d == START) || (state_d == STOP);
        to_flag_d = to_set | (to_flag_q & ~clr_to_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            af_q      <= 1'b0;
            deb_cnt_q <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            k1_q      <= 1'b0;
            k2_q      <= 1'b0;
            to_flag_q <= 1'b0;
        end else begin
            s1_q      <= a_i;
            s2_q      <= s1_q;
            af_q      <= af_d;
            deb_cnt_q <= deb_cnt_d;
            rise_q    <= af_d & ~af_q;
            fall_q    <= ~af_d & af_q;
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            k1_q      <= k1_d;
            k2_q      <= k2_d;
            to_flag_q <= to_flag_d;
        end
    end

`ifdef PHASE_SEQ_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cyc_q <= '0;
        else if (k2_d) cyc_q <= cyc_q + 1'b1;
    end
    assign cyc_o = cyc_q;
`else
    assign cyc_o = '0;
`endif

    assign k1_o      = k1_q;
    assign k2_o      = k2_q;
    assign to_flag_o = to_flag_q;
    assign state_o   = state_q;
endmodule

module phase_seq_fsm #(
    parameter int CH      = 4,
    parameter int DEB_W   = 4,
    parameter int DEB_CNT = 8,
    parameter int TO_W    = 16,
    parameter int TO_CNT  = 1000,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CH-1:0]       a,
    input  logic                clr_to,
    output logic [CH-1:0]       k1,
    output logic [CH-1:0]       k2,
    output logic [CH-1:0]       to_flag,
    output logic [2*CH-1:0]     state_o,
    output logic [CNT_W*CH-1:0] cyc_cnt
);
    for (genvar i = 0; i < CH; i++) begin : g_ch
        phase_seq_ch #(
            .DEB_W(DEB_W), .DEB_CNT(DEB_CNT), .TO_W(TO_W), .TO_CNT(TO_CNT), .CNT_W(CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en),
            .a_i       (a[i]),
            .clr_to_i  (clr_to),
            .k1_o      (k1[i]),
            .k2_o      (k2[i]),
            .to_flag_o (to_flag[i]),
            .state_o   (state_o[2*i +: 2]),
            .cyc_o     (cyc_cnt[CNT_W*i +: CNT_W])
        );
    end
endmodule
